arb6_rr_mux: RTL and testbench

- Six-requester round-robin arbiter and registered output stage for a 6-input one-hot AND-OR data mux.
- Generates the one-hot select vector, holds the grant for the full length of a multi-beat packet, and registers the selected beat behind a valid/ready handshake.
- Sits between six producer streams and one shared downstream consumer.

---
 rtl/arb6_rr_mux_if.sv | 31 +++
 rtl/arb6_rr_mux.sv | 132 +++++++++++++
 tb/tb_arb6_rr_mux.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/arb6_rr_mux_if.sv
// Stream bundle between six producers, the round-robin arbiter and one consumer.
// slave: arbiter side; master: producer/consumer (testbench) side.
interface arb6_rr_mux_if #(
    parameter int DW = 1
);
    logic [5:0]    in_valid;
    logic [5:0]    in_last;
    logic [5:0]    in_ready;
    logic [DW-1:0] in0;
    logic [DW-1:0] in1;
    logic [DW-1:0] in2;
    logic [DW-1:0] in3;
    logic [DW-1:0] in4;
    logic [DW-1:0] in5;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic [5:0]    out_src;
    logic          out_ready;
    logic          lock_err;

    modport slave (
        input  in_valid, in_last, in0, in1, in2, in3, in4, in5, out_ready,
        output in_ready, out_valid, out_data, out_last, out_src, lock_err
    );

    modport master (
        output in_valid, in_last, in0, in1, in2, in3, in4, in5, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_src, lock_err
    );
endinterface

// File: rtl/arb6_rr_mux.sv
// Six-way round-robin packet arbiter with a one-hot AND-OR mux and a registered output beat.
// Optional lock timeout enabled by defining ARB6_LOCK_TIMEOUT_EN.
module arb6_rr_mux #(
    parameter int DW  = 1,
    parameter int TMO = 16
) (
    input  logic          clk,
    input  logic          reset,
    arb6_rr_mux_if.slave  bus
);
    typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

    state_t        r_state;
    logic [2:0]    r_lock_id;
    logic [2:0]    r_ptr;
    logic          r_out_valid;
    logic          r_out_last;
    logic [DW-1:0] r_out_data;
    logic [5:0]    r_out_src;
`ifdef ARB6_LOCK_TIMEOUT_EN
    logic [7:0]    r_cnt;
    logic          r_lock_err;
`endif

    logic [DW-1:0] w_in [6];
    logic [DW-1:0] w_mux;
    logic [5:0]    w_grant;
    logic [2:0]    w_gidx;
    logic [2:0]    w_gnext;
    logic [3:0]    w_idx;
    logic          w_load;
    logic          w_xfer;
    logic          w_last;

    assign w_in[0] = bus.in0;
    assign w_in[1] = bus.in1;
    assign w_in[2] = bus.in2;
    assign w_in[3] = bus.in3;
    assign w_in[4] = bus.in4;
    assign w_in[5] = bus.in5;

    // Walk the search order backwards so the candidate closest to ptr is written last and wins.
    always_comb begin
        w_grant = '0;
        w_gidx  = '0;
        w_idx   = '0;
        if (r_state == ST_LOCKED) begin
            w_grant = 6'b1 << r_lock_id;
            w_gidx  = r_lock_id;
        end else begin
            for (int k = 5; k >= 0; k--) begin
                w_idx = {1'b0, r_ptr} + 4'(k);
                if (w_idx >= 4'd6) w_idx = w_idx - 4'd6;
                if (|(bus.in_valid & (6'b1 << w_idx[2:0]))) begin
                    w_grant = 6'b1 << w_idx[2:0];
                    w_gidx  = w_idx[2:0];
                end
            end
        end
    end

    always_comb begin
        w_mux = '0;
        for (int i = 0; i < 6; i++) w_mux = w_mux | ({DW{w_grant[i]}} & w_in[i]);
    end

    assign w_load  = ~r_out_valid | bus.out_ready;
    assign w_xfer  = w_load & (|(bus.in_valid & w_grant));
    assign w_last  = |(bus.in_last & w_grant);
    assign w_gnext = (w_gidx == 3'd5) ? 3'd0 : w_gidx + 3'd1;

    assign bus.in_ready  = w_grant & {6{w_load & ~reset}};
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_last  = r_out_last;
    assign bus.out_src   = r_out_src;
`ifdef ARB6_LOCK_TIMEOUT_EN
    assign bus.lock_err  = r_lock_err;
`else
    assign bus.lock_err  = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_lock_id   <= '0;
            r_ptr       <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= '0;
`ifdef ARB6_LOCK_TIMEOUT_EN
            r_cnt       <= '0;
            r_lock_err  <= 1'b0;
`endif
        end else begin
            if (w_load) begin
                if (w_xfer) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= w_mux;
                    r_out_last  <= w_last;
                    r_out_src   <= w_grant;
                    if (w_last) begin
                        r_state <= ST_IDLE;
                        r_ptr   <= w_gnext;
                    end else begin
                        r_state   <= ST_LOCKED;
                        r_lock_id <= w_gidx;
                    end
                end else begin
                    r_out_valid <= 1'b0;
                end
            end
`ifdef ARB6_LOCK_TIMEOUT_EN
            // A lock owner that goes quiet for TMO cycles forfeits the lock; priority moves past it.
            r_lock_err <= 1'b0;
            if (w_xfer) begin
                r_cnt <= '0;
            end else if ((r_state == ST_LOCKED) && !(|(bus.in_valid & w_grant))) begin
                if (r_cnt == 8'(TMO - 1)) begin
                    r_cnt      <= '0;
                    r_state    <= ST_IDLE;
                    r_ptr      <= w_gnext;
                    r_lock_err <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 8'd1;
                end
            end
`endif
        end
    end
endmodule

// File: tb/tb_arb6_rr_mux.sv
// Directed bench for arb6_rr_mux with a cycle model of the arbitration rules.
// Timeout scenario expectations depend on ARB6_LOCK_TIMEOUT_EN.
module tb_arb6_rr_mux;
    localparam int DW  = 4;
    localparam int TMO = 4;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    arb6_rr_mux_if #(.DW(DW)) bus ();
    arb6_rr_mux #(.DW(DW), .TMO(TMO)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Model: lock owner (-1 = none), rotating pointer and the registered output beat.
    int            m_lock;
    int            m_ptr;
    logic          m_valid;
    logic          m_last;
    logic          m_err;
    logic [DW-1:0] m_data;
    logic [5:0]    m_src;
`ifdef ARB6_LOCK_TIMEOUT_EN
    int            m_cnt;
`endif

    function automatic logic [DW-1:0] din(input int g);
        case (g)
            0: return bus.in0;
            1: return bus.in1;
            2: return bus.in2;
            3: return bus.in3;
            4: return bus.in4;
            default: return bus.in5;
        endcase
    endfunction

    function automatic int m_gnt();
        if (m_lock >= 0) return m_lock;
        for (int k = 0; k < 6; k++) begin
            if (bus.in_valid[(m_ptr + k) % 6]) return (m_ptr + k) % 6;
        end
        return -1;
    endfunction

    task automatic m_reset();
        m_lock = -1; m_ptr = 0; m_valid = 1'b0; m_last = 1'b0;
        m_err = 1'b0; m_data = '0; m_src = '0;
`ifdef ARB6_LOCK_TIMEOUT_EN
        m_cnt = 0;
`endif
    endtask

    task automatic m_step();
        int   g;
        logic ld;
        logic x;
        g  = m_gnt();
        ld = !m_valid || bus.out_ready;
        x  = ld && (g >= 0) && bus.in_valid[g];
        m_err = 1'b0;
        if (x) begin
            m_data  = din(g);
            m_last  = bus.in_last[g];
            m_src   = 6'(1 << g);
            m_valid = 1'b1;
            if (bus.in_last[g]) begin
                m_lock = -1;
                m_ptr  = (g + 1) % 6;
            end else begin
                m_lock = g;
            end
`ifdef ARB6_LOCK_TIMEOUT_EN
            m_cnt = 0;
`endif
        end else if (ld) begin
            m_valid = 1'b0;
        end
`ifdef ARB6_LOCK_TIMEOUT_EN
        if (!x && m_lock >= 0 && !bus.in_valid[m_lock]) begin
            m_cnt++;
            if (m_cnt == TMO) begin
                m_err  = 1'b1;
                m_ptr  = (m_lock + 1) % 6;
                m_lock = -1;
                m_cnt  = 0;
            end
        end
`endif
    endtask

    function automatic logic [5:0] m_ready();
        int g;
        g = m_gnt();
        if (reset || !(!m_valid || bus.out_ready) || g < 0) return 6'h00;
        return 6'(1 << g);
    endfunction

    initial begin
        m_reset();
        forever begin
            @(negedge clk);
            #1;
            if (reset) m_reset();
            chk("cmp_out_valid", 32'(bus.out_valid), 32'(m_valid));
            chk("cmp_out_data",  32'(bus.out_data),  32'(m_data));
            chk("cmp_out_last",  32'(bus.out_last),  32'(m_last));
            chk("cmp_out_src",   32'(bus.out_src),   32'(m_src));
            chk("cmp_lock_err",  32'(bus.lock_err),  32'(m_err));
            chk("cmp_in_ready",  32'(bus.in_ready),  32'(m_ready()));
            @(posedge clk);
            if (reset) m_reset();
            else m_step();
        end
    end

    task automatic drv(input logic [5:0] v, input logic [5:0] l, input logic r);
        bus.in_valid  = v;
        bus.in_last   = l;
        bus.out_ready = r;
    endtask

    task automatic rdy(input string name, input logic [5:0] e);
        #1;
        chk(name, 32'(bus.in_ready), 32'(e));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'h0);
        chk({tag, "_data"},  32'(bus.out_data),  32'h0);
        chk({tag, "_last"},  32'(bus.out_last),  32'h0);
        chk({tag, "_src"},   32'(bus.out_src),   32'h0);
        chk({tag, "_err"},   32'(bus.lock_err),  32'h0);
        chk({tag, "_rdy"},   32'(bus.in_ready),  32'h0);
    endtask

    initial begin
        reset = 1'b1;
        drv(6'h00, 6'h00, 1'b0);
        bus.in0 = 4'd0; bus.in1 = 4'd1; bus.in2 = 4'd2;
        bus.in3 = 4'd3; bus.in4 = 4'd4; bus.in5 = 4'd5;
        #6;
        chk_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        // Round-robin rotation, all single-beat.
        @(negedge clk);
        drv(6'h3F, 6'h3F, 1'b1);
        rdy("rr_rdy0", 6'h01);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk("rr_src",   32'(bus.out_src),   32'(1 << (i % 6)));
            chk("rr_data",  32'(bus.out_data),  32'(i % 6));
            chk("rr_valid", 32'(bus.out_valid), 32'h1);
        end
        drv(6'h00, 6'h00, 1'b1);

        // Requester 2 three-beat packet while requester 4 waits; ptr=1.
        @(negedge clk);
        drv(6'h14, 6'h10, 1'b1);
        rdy("lk_rdy1", 6'h04);
        @(negedge clk);
        chk("lk_src1", 32'(bus.out_src), 32'h04);
        chk("lk_last1", 32'(bus.out_last), 32'h0);
        rdy("lk_rdy2", 6'h04);
        @(negedge clk);
        chk("lk_src2", 32'(bus.out_src), 32'h04);
        drv(6'h14, 6'h14, 1'b1);
        rdy("lk_rdy3", 6'h04);
        @(negedge clk);
        chk("lk_src3", 32'(bus.out_src), 32'h04);
        chk("lk_last3", 32'(bus.out_last), 32'h1);
        rdy("lk_rdy4", 6'h10);
        @(negedge clk);
        chk("lk_src4", 32'(bus.out_src), 32'h10);
        drv(6'h00, 6'h00, 1'b1);

        // Pointer wrap: ptr=5, requesters 1 and 5.
        @(negedge clk);
        drv(6'h22, 6'h3F, 1'b1);
        rdy("wr_rdy5", 6'h20);
        @(negedge clk);
        chk("wr_src5", 32'(bus.out_src), 32'h20);
        rdy("wr_rdy1", 6'h02);
        @(negedge clk);
        chk("wr_src1", 32'(bus.out_src), 32'h02);
        drv(6'h00, 6'h00, 1'b1);
        @(negedge clk);
        chk("wr_idle", 32'(bus.out_valid), 32'h0);

        // Backpressure on requester 0.
        drv(6'h01, 6'h01, 1'b0);
        bus.in0 = 4'd7;
        rdy("bp_rdy_first", 6'h01);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", 32'(bus.out_valid), 32'h1);
            chk("bp_hold_data",  32'(bus.out_data),  32'h7);
            bus.in0 = 4'd8;
            rdy("bp_stall_rdy", 6'h00);
        end
        @(negedge clk);
        chk("bp_hold_data5", 32'(bus.out_data), 32'h7);
        bus.out_ready = 1'b1;
        rdy("bp_release_rdy", 6'h01);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("bp_stream_data",  32'(bus.out_data),  32'(8 + j));
            chk("bp_stream_valid", 32'(bus.out_valid), 32'h1);
            bus.in0 = 4'(9 + j);
        end
        drv(6'h00, 6'h00, 1'b1);
        bus.in0 = 4'd0;
        @(negedge clk);
        chk("bp_drain", 32'(bus.out_valid), 32'h0);

        // Reset after beat 1 of a four-beat packet from requester 3.
        drv(6'h08, 6'h00, 1'b1);
        rdy("rs_rdy3", 6'h08);
        @(negedge clk);
        chk("rs_src3", 32'(bus.out_src), 32'h08);
        chk("rs_last", 32'(bus.out_last), 32'h0);
        reset = 1'b1;
        #1;
        chk_zero("rs_async");
        @(negedge clk);
        reset = 1'b0;
        drv(6'h09, 6'h09, 1'b1);
        rdy("rs_rdy0", 6'h01);
        @(negedge clk);
        chk("rs_src0", 32'(bus.out_src), 32'h01);
        chk("rs_data0", 32'(bus.out_data), 32'h0);
        drv(6'h00, 6'h00, 1'b1);
        @(negedge clk);

        // Requester 1 opens a packet then goes quiet; requester 2 waits.
        drv(6'h06, 6'h04, 1'b1);
        rdy("to_rdy1", 6'h02);
        @(negedge clk);
        chk("to_src1", 32'(bus.out_src), 32'h02);
        drv(6'h04, 6'h04, 1'b1);
        rdy("to_lock_rdy", 6'h02);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("to_err_quiet", 32'(bus.lock_err), 32'h0);
            rdy("to_lock_rdy", 6'h02);
        end
        @(negedge clk);
`ifdef ARB6_LOCK_TIMEOUT_EN
        chk("to_err_pulse", 32'(bus.lock_err), 32'h1);
        rdy("to_rdy2", 6'h04);
        @(negedge clk);
        chk("to_err_clear", 32'(bus.lock_err), 32'h0);
        chk("to_src2", 32'(bus.out_src), 32'h04);
`else
        chk("to_err_none", 32'(bus.lock_err), 32'h0);
        rdy("to_still_locked", 6'h02);
        @(negedge clk);
        chk("to_err_none2", 32'(bus.lock_err), 32'h0);
        chk("to_no_beat", 32'(bus.out_valid), 32'h0);
`endif
        drv(6'h00, 6'h00, 1'b1);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end
endmodule
